// File: rtl/vga_scan_gen.sv
// Raster timing generator and registered VGA pixel output stage for the scoreboard display.
// Optional build macro VGA_SCAN_BORDER_EN adds a 1-pixel FG_COLOR frame around the active area.
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned PIX_LAT  = 0,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        line_tick,
  output logic        frame_tick,
  input  logic        pixel_on_in,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Delayed tag bits: [0]=act, [1]=hs, [2]=vs, [3]=border (border build only)
`ifdef VGA_SCAN_BORDER_EN
  localparam int unsigned TAG_W = 4;
`else
  localparam int unsigned TAG_W = 3;
`endif

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;

  logic             act_raw;
  logic             hs_raw;
  logic             vs_raw;
  logic [TAG_W-1:0] tag_raw;
  logic [TAG_W-1:0] tag_dly;

  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign x          = h_cnt_q;
  assign y          = v_cnt_q;
  assign line_tick  = (h_cnt_q == 12'd0);
  assign frame_tick = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);

  // Vsync decodes on y alone, so its edges land on x==0 and span whole lines.
  always_comb begin
    act_raw = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hs_raw  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs_raw  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
`ifdef VGA_SCAN_BORDER_EN
    tag_raw = {act_raw && ((h_cnt_q == 12'd0) || (h_cnt_q == H_ACT_LAST) ||
                           (v_cnt_q == 11'd0) || (v_cnt_q == V_ACT_LAST)),
               vs_raw, hs_raw, act_raw};
`else
    tag_raw = {vs_raw, hs_raw, act_raw};
`endif
  end

  // Match the digit blocks' latency so the tag meets its pixel_on_in.
  generate
    if (PIX_LAT == 0) begin : g_no_dly
      assign tag_dly = tag_raw;
    end else begin : g_dly
      logic [TAG_W-1:0] pipe_q [PIX_LAT];
      logic [TAG_W-1:0] pipe_d [PIX_LAT];

      always_comb begin
        pipe_d[0] = tag_raw;
        for (int i = 1; i < int'(PIX_LAT); i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_q <= '{default: '0};
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign tag_dly = pipe_q[PIX_LAT-1];
    end
  endgenerate

  always_comb begin
    rgb_d = '0;
    if (tag_dly[0]) begin
      rgb_d = pixel_on_in ? FG_COLOR : BG_COLOR;
`ifdef VGA_SCAN_BORDER_EN
      if (tag_dly[3]) begin
        rgb_d = FG_COLOR;
      end
`endif
    end
    hsync_d    = tag_dly[1] ? HS_POL : ~HS_POL;
    vsync_d    = tag_dly[2] ? VS_POL : ~VS_POL;
    video_on_d = tag_dly[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q      <= '0;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      video_on_q <= 1'b0;
    end else begin
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign rgb      = rgb_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen using a 16x8 raster with PIX_LAT=2.
// Expected outputs are queued per coordinate and retired PIX_LAT+1 cycles later.
module tb_vga_scan_gen;

   localparam int PIX_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pixelOnIn = 1'b0;
   logic [11:0] x;
   logic [10:0] y;
   logic        lineTick;
   logic        frameTick;
   logic        hsync;
   logic        vsync;
   logic        videoOn;
   logic [11:0] rgb;

   int checks = 0;
   int errors = 0;
   int mx;
   int my;
   int mode;
   int lineCount;
   int frameCount;
   int guard;

   logic [14:0] expQ[$];
   logic        pixQ[$];

   // Clock generation: 10 time-unit period, posedge at 5, 15, ...
   always #5 clk = ~clk;

   vga_scan_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(PIX_LAT),
      .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .y(y),
      .line_tick(lineTick), .frame_tick(frameTick),
      .pixel_on_in(pixelOnIn),
      .hsync(hsync), .vsync(vsync), .video_on(videoOn), .rgb(rgb)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model of one output record: {video_on, hsync, vsync, rgb}
   function automatic logic [14:0] expOut(input int cx, input int cy, input logic p);
      logic a, h, v;
      logic [11:0] c;
      a = (cx < 8) && (cy < 4);
      h = (cx >= 10) && (cx < 13);
      v = (cy == 5);
      c = 12'h000;
      if (a) c = p ? 12'hFFF : 12'h000;
`ifdef VGA_SCAN_BORDER_EN
      if (a && (cx == 0 || cx == 7 || cy == 0 || cy == 3)) c = 12'hFFF;
`endif
      return {a, h, v, c};
   endfunction

   // Restart the model at (0,0) with the cleared delay line represented as inactive records
   task automatic resetModel();
      mx = 0;
      my = 0;
      expQ.delete();
      pixQ.delete();
      repeat (PIX_LAT + 1) expQ.push_back(15'h0);
      repeat (PIX_LAT) pixQ.push_back(1'b0);
   endtask

   // One pixel clock: check counters/ticks, queue expectation, retire oldest, drive pixel
   task automatic applyStimulus();
      logic p;
      logic [14:0] e;
      @(negedge clk);
      checkOutput("x", 32'(x), 32'(mx));
      checkOutput("y", 32'(y), 32'(my));
      checkOutput("line_tick", 32'(lineTick), 32'(mx == 0));
      checkOutput("frame_tick", 32'(frameTick), 32'(mx == 0 && my == 0));
      if (lineTick) lineCount++;
      if (frameTick) frameCount++;
      if (mode == 0) p = ((mx == 5) && (my == 2)) || !((mx < 8) && (my < 4));
      else           p = 1'($urandom_range(0, 1));
      expQ.push_back(expOut(mx, my, p));
      pixQ.push_back(p);
      e = expQ.pop_front();
      checkOutput("video_on", 32'(videoOn), 32'(e[14]));
      checkOutput("hsync", 32'(hsync), 32'(e[13]));
      checkOutput("vsync", 32'(vsync), 32'(e[12]));
      checkOutput("rgb", 32'(rgb), 32'(e[11:0]));
      pixelOnIn = pixQ.pop_front();
      mx++;
      if (mx == 16) begin
         mx = 0;
         my = (my + 1) % 8;
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_x"}, 32'(x), 32'd0);
      checkOutput({tag, "_y"}, 32'(y), 32'd0);
      checkOutput({tag, "_rgb"}, 32'(rgb), 32'd0);
      checkOutput({tag, "_video_on"}, 32'(videoOn), 32'd0);
      checkOutput({tag, "_hsync"}, 32'(hsync), 32'd0);
      checkOutput({tag, "_vsync"}, 32'(vsync), 32'd0);
      checkOutput({tag, "_line_tick"}, 32'(lineTick), 32'd1);
      checkOutput({tag, "_frame_tick"}, 32'(frameTick), 32'd1);
   endtask

   initial begin
      // Power-on reset held for 5 cycles
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");

      // Release just after a posedge so the first sampled cycle still shows (0,0)
      @(posedge clk);
      #2 rst = 1'b1;
      resetModel();
      mode = 0;
      lineCount = 0;
      frameCount = 0;
      repeat (256) applyStimulus();
      checkOutput("line_tick_count", 32'(lineCount), 32'd16);
      checkOutput("frame_tick_count", 32'(frameCount), 32'd2);

      // Advance to (9,3) and assert reset asynchronously mid-frame
      guard = 0;
      while (!(mx == 9 && my == 3) && guard < 200) begin
         applyStimulus();
         guard++;
      end
      checkOutput("reach_9_3", 32'(mx == 9 && my == 3), 32'd1);
      @(negedge clk);
      checkOutput("pre_reset_x", 32'(x), 32'd9);
      checkOutput("pre_reset_y", 32'(y), 32'd3);
      #2 rst = 1'b0;
      #1 checkResetValues("async_reset");
      repeat (2) @(posedge clk);

      // Random pixel stream across a full frame from (0,0)
      @(posedge clk);
      #2 rst = 1'b1;
      resetModel();
      mode = 1;
      lineCount = 0;
      frameCount = 0;
      repeat (144) applyStimulus();
      checkOutput("frame_tick_after_reset", 32'(frameCount), 32'd2);
      checkOutput("line_tick_after_reset", 32'(lineCount), 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster timing generator and pixel output stage for the scoreboard display. It sweeps the `x`/`y` scan coordinates that every digit block (stopwatch, score, and other `counter_flop` instances) consumes. It collects their OR-ed `pixel_on` result and drives registered, latency-aligned `hsync`, `vsync` and `rgb` to the VGA connector. It is the source end of the `x`/`y` → `pixel_on` interface.

## Interface
Parameters:
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 48, horizontal front porch (pixels)
- `H_SYNC`, 112, hsync pulse width (pixels)
- `H_BP`, 248, horizontal back porch (pixels); H_TOTAL = sum = 1688
- `V_ACTIVE`, 1024, visible lines
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vsync pulse width (lines)
- `V_BP`, 38, vertical back porch (lines); V_TOTAL = sum = 1066
- `HS_POL`, 1, active level of hsync
- `VS_POL`, 1, active level of vsync
- `PIX_LAT`, 0, cycles from `x`/`y` to the matching `pixel_on_in` (range 0..7)
- `FG_COLOR`, 12'hFFF, 4:4:4 colour for lit pixels
- `BG_COLOR`, 12'h000, 4:4:4 colour for unlit active pixels

Ports:
- `clk`  in  1  pixel clock (108 MHz at default timing)
- `rst`  in  1  asynchronous reset, active-low
- `x`  out  12  current horizontal count, 0..H_TOTAL-1
- `y`  out  11  current vertical count, 0..V_TOTAL-1
- `line_tick`  out  1  high while `x`==0
- `frame_tick`  out  1  high while `x`==0 and `y`==0
- `pixel_on_in`  in  1  OR of all digit-block `pixel_on`, valid PIX_LAT cycles after its `x`/`y`
- `hsync`  out  1  registered, aligned with `rgb`
- `vsync`  out  1  registered, aligned with `rgb`
- `video_on`  out  1  registered, aligned with `rgb`; high in the active region
- `rgb`  out  12  registered pixel colour

## Operation
- **Counters.**
  - The horizontal counter increments every cycle and wraps from H_TOTAL-1 to 0.
  - The vertical counter increments only on the horizontal wrap and wraps from V_TOTAL-1 to 0.
  - `x`/`y` are the counter registers themselves, with no output logic.
- **Raw decode per cycle (undelayed).**
  - `act` = (`x` < H_ACTIVE) && (`y` < V_ACTIVE).
  - `hs` = H_ACTIVE+H_FP ≤ `x` < H_ACTIVE+H_FP+H_SYNC.
  - `vs` = V_ACTIVE+V_FP ≤ `y` < V_ACTIVE+V_FP+V_SYNC. Vsync is whole lines, with edges at `x`==0.
- **Delay line.** `act`, `hs` and `vs` pass through a PIX_LAT-deep shift register, so they arrive together with `pixel_on_in`.
- **Output register.** One final register stage drives:
  - `rgb` = act_d ? (pixel_on_in ? FG_COLOR : BG_COLOR) : 0
  - `hsync` = hs_d ? HS_POL : ~HS_POL
  - `vsync` = vs_d ? VS_POL : ~VS_POL
  - `video_on` = act_d
- **Blanking.** `pixel_on_in` is ignored outside the active region; `rgb` is forced to 0 there.
- **Reset (asserted, any time).**
  - Counters go to 0.
  - The delay line clears to inactive.
  - `rgb` = 0, `video_on` = 0, `hsync` = ~HS_POL, `vsync` = ~VS_POL.
  - `line_tick` and `frame_tick` read 1, because the counters are at 0.
- **Reset release.** The first counting edge moves `x` to 1. Reset mid-frame restarts the frame at (0,0) with no partial-line recovery.

## Timing
- Coordinate to output latency is PIX_LAT+1 cycles. The pixel for `x`=N on cycle t appears on `rgb` at t+PIX_LAT+1, and `hsync`/`vsync`/`video_on` are skewed identically.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL×V_TOTAL cycles (1,799,408 at defaults).
- `line_tick` is a 1-cycle pulse every H_TOTAL cycles. `frame_tick` is a 1-cycle pulse every frame. Neither tick is delayed.
- At the simultaneous horizontal and vertical wrap, both counters return to 0 on the same edge.
- After reset release, the first `rgb`/`video_on` high occurs PIX_LAT+1 cycles after release.

## Configuration
- `VGA_SCAN_BORDER_EN` **defined:** active pixels with `x`∈{0, H_ACTIVE-1} or `y`∈{0, V_ACTIVE-1} output FG_COLOR regardless of `pixel_on_in`. This 1-pixel frame is used for monitor alignment. The border flag is delayed with `act`.
- `VGA_SCAN_BORDER_EN` **undefined:** no border logic is present, and `rgb` depends only on `act_d` and `pixel_on_in`.

## Test plan
Benches use small timing: H 8/2/3/3 (total 16), V 4/1/1/2 (total 8), PIX_LAT=2, FG=12'hFFF, BG=12'h000.

- **Reset values.** Hold `rst` low for 5 cycles → `x`=0, `y`=0, `rgb`=0, `video_on`=0, `hsync`=0, `vsync`=0, `frame_tick`=1.
- **Sweep.** Release reset and run 2 frames →
  - `x` cycles 0..15.
  - `y` steps on each `x` wrap and cycles 0..7.
  - `line_tick` is seen every 16 cycles and `frame_tick` every 128 cycles.
- **Sync widths and alignment.**
  - `hsync` is high for exactly 3 cycles, starting 3 cycles after `x`=10.
  - `vsync` is high for exactly 16 cycles, starting 3 cycles after (`x`=0, `y`=5).
- **Pixel alignment.** Drive `pixel_on_in` = 1 exactly PIX_LAT cycles after `x`=5,`y`=2 → `rgb`=12'hFFF for one cycle, 3 cycles after `x`=5; `rgb`=12'h000 at all other active slots. `pixel_on_in` held 1 during blanking → `rgb` stays 0.
- **Reset mid-frame.** Assert `rst` at `x`=9,`y`=3 → all outputs take reset values immediately, without waiting for a clock edge; after release, a full frame of 128 cycles follows from (0,0).
- **Border.** With `VGA_SCAN_BORDER_EN` and `pixel_on_in`=0 → `rgb`=12'hFFF for `x`∈{0,7} or `y`∈{0,3} inside the active region, 12'h000 elsewhere in the active region. Without the macro, the same stimulus gives all-zero `rgb`.
